// File: rtl/usb_buf_in_arbiter_pkg.sv
// Shared types and constants for the USB IN-buffer arbiter.
package usb_buf_arb_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILL     = 2'd1,
        COMMIT   = 2'd2,
        WAIT_RDY = 2'd3
    } arb_state_e;

    localparam int MAX_PKT_DEF = 512;
    localparam int LEN_W       = 10;
    localparam int ADDR_W      = 9;
endpackage

// File: rtl/usb_buf_in_arbiter_if.sv
// Write/commit port of the USB core's single IN-endpoint packet buffer.
interface usb_buf_in_arbiter_if;
    import usb_buf_arb_pkg::*;

    logic [ADDR_W-1:0] buf_in_addr;
    logic [7:0]        buf_in_data;
    logic              buf_in_wren;
    logic              buf_in_ready;
    logic              buf_in_commit;
    logic [LEN_W-1:0]  buf_in_commit_len;
    logic              buf_in_commit_ack;

    modport master (
        output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
        input  buf_in_ready, buf_in_commit_ack
    );
    modport slave (
        input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
        output buf_in_ready, buf_in_commit_ack
    );
endinterface

// File: rtl/usb_buf_in_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves to the
// other source whenever the current owner releases.
module usb_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       rel,
    input  logic       rel_idx,
    output logic [1:0] gnt
);
    logic ptr_q, ptr_d;

    always_comb begin
        gnt   = req;
        ptr_d = ptr_q;
        if (&req) gnt = ptr_q ? 2'b10 : 2'b01;
        if (rel)  ptr_d = ~rel_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/usb_buf_in_arbiter.sv
// Shares the USB IN packet buffer between two byte-stream sources:
// grant one, write its bytes, commit the packet, split/ZLP as needed.
module usb_buf_in_arbiter
    import usb_buf_arb_pkg::*;
#(
    parameter int MAX_PKT  = MAX_PKT_DEF,
    parameter bit AUTO_ZLP = 1'b1
) (
    input  logic              ext_clk,
    input  logic              reset_n,
    input  logic [7:0]        src0_data,
    input  logic              src0_valid,
    input  logic              src0_last,
    input  logic              src0_zlp,
    output logic              src0_ready,
    input  logic [7:0]        src1_data,
    input  logic              src1_valid,
    input  logic              src1_last,
    input  logic              src1_zlp,
    output logic              src1_ready,
    usb_buf_in_arbiter_if.master buf_in,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [15:0]       pkt_count
);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT);

    logic [1:0][7:0] s_data;
    logic [1:0]      s_valid, s_last, s_zlp, s_req, arb_gnt;

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [LEN_W-1:0]  count_q, count_d, count_inc;
    logic              split_q, split_d, zlp_pend_q, zlp_pend_d;
    logic              commit_q, commit_d, wren_q, wren_d, rel;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [15:0]       pkt_q, pkt_d;

    assign s_data  = {src1_data, src0_data};
    assign s_valid = {src1_valid, src0_valid};
    assign s_last  = {src1_last, src0_last};
    assign s_zlp   = {src1_zlp, src0_zlp};
    assign s_req   = s_valid | s_zlp;

    usb_rr_arb2 u_rr (
        .clk    (ext_clk),
        .rst_n  (reset_n),
        .req    (s_req),
        .rel    (rel),
        .rel_idx(owner_q),
        .gnt    (arb_gnt)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        count_d    = count_q;
        split_d    = split_q;
        zlp_pend_d = zlp_pend_q;
        commit_d   = commit_q;
        wren_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        pkt_d      = pkt_q;
        rel        = 1'b0;
        count_inc  = count_q + LEN_W'(1);
        case (state_q)
            IDLE: if (buf_in.buf_in_ready && |s_req) begin
                state_d = FILL;
                owner_d = arb_gnt[1];
            end
            FILL: if (s_valid[owner_q]) begin
                wren_d  = 1'b1;
                addr_d  = count_q[ADDR_W-1:0];
                data_d  = s_data[owner_q];
                count_d = count_inc;
                if (s_last[owner_q] || count_inc == MAX_LEN) begin
                    state_d    = COMMIT;
                    split_d    = !s_last[owner_q];
                    zlp_pend_d = s_last[owner_q] && count_inc == MAX_LEN && AUTO_ZLP;
                end
            end else if (s_zlp[owner_q] && count_q == '0) begin
                state_d = COMMIT;
            end
            // Commit rises one cycle after entering, so the final wren always leads it.
            COMMIT: if (!commit_q) begin
                commit_d = 1'b1;
            end else if (buf_in.buf_in_commit_ack) begin
                commit_d = 1'b0;
                pkt_d    = pkt_q + 16'd1;
                count_d  = '0;
                split_d  = 1'b0;
                if (split_q || zlp_pend_q) begin
                    state_d = WAIT_RDY;
                end else begin
                    state_d = IDLE;
                    rel     = 1'b1;
                end
            end
            WAIT_RDY: if (buf_in.buf_in_ready) begin
                state_d    = zlp_pend_q ? COMMIT : FILL;
                zlp_pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            count_q    <= '0;
            split_q    <= 1'b0;
            zlp_pend_q <= 1'b0;
            commit_q   <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            pkt_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            count_q    <= count_d;
            split_q    <= split_d;
            zlp_pend_q <= zlp_pend_d;
            commit_q   <= commit_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            pkt_q      <= pkt_d;
        end
    end

    assign src0_ready               = (state_q == FILL) && !owner_q;
    assign src1_ready               = (state_q == FILL) &&  owner_q;
    assign grant                    = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign busy                     = (state_q != IDLE);
    assign pkt_count                = pkt_q;
    assign buf_in.buf_in_addr       = addr_q;
    assign buf_in.buf_in_data       = data_q;
    assign buf_in.buf_in_wren       = wren_q;
    assign buf_in.buf_in_commit     = commit_q;
    assign buf_in.buf_in_commit_len = commit_q ? count_q : '0;
endmodule

// File: tb/tb_usb_buf_in_arbiter.sv
// Bench for usb_buf_in_arbiter: directed scenarios plus random streams,
// checked against a packetisation model of each stream.
module tb_usb_buf_in_arbiter;
    localparam int MAX_PKT = 512;
    localparam int LIM     = 20000;

    logic            ext_clk, reset_n;
    logic [1:0][7:0] sd;
    logic [1:0]      sv, sl, sz;
    wire             srdy0, srdy1;
    logic [1:0]      grant;
    logic            busy;
    logic [15:0]     pkt_count;

    usb_buf_in_arbiter_if bif();

    usb_buf_in_arbiter #(.MAX_PKT(MAX_PKT), .AUTO_ZLP(1'b1)) dut (
        .ext_clk(ext_clk), .reset_n(reset_n),
        .src0_data(sd[0]), .src0_valid(sv[0]), .src0_last(sl[0]), .src0_zlp(sz[0]), .src0_ready(srdy0),
        .src1_data(sd[1]), .src1_valid(sv[1]), .src1_last(sl[1]), .src1_zlp(sz[1]), .src1_ready(srdy1),
        .buf_in(bif), .grant(grant), .busy(busy), .pkt_count(pkt_count)
    );

    initial begin
        ext_clk = 1'b0;
        forever #5 ext_clk = ~ext_clk;
    end

    int n_chk = 0, n_fail = 0;
    logic [7:0] strm [2][0:2047];
    int slen [2];
    logic [31:0] exp_wr[$], act_wr[$], exp_cm[$], act_cm[$];
    int exp_pkts = 0, gap_pct = 0, ack_max = 0, hold_once = 0, wr_in_hold = 0;
    int rdy_cnt [2];
    bit rand_rdy = 0;

    function automatic logic rdy_of(input int s);
        return (s == 0) ? srdy0 : srdy1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected buffer traffic for n bytes of source s: byte i lands at i mod MAX_PKT,
    // packets are MAX_PKT chunks plus remainder, or a trailing ZLP when it divides evenly.
    function automatic void model_stream(input int s, input int n, input bit ends);
        logic [1:0] g = (s == 0) ? 2'b01 : 2'b10;
        for (int i = 0; i < n; i++)
            exp_wr.push_back({13'd0, g, 9'(i % MAX_PKT), strm[s][i]});
        if (!ends) return;
        for (int k = 0; k < n / MAX_PKT; k++) begin
            exp_cm.push_back({20'd0, g, 10'(MAX_PKT)});
            exp_pkts++;
        end
        if (n % MAX_PKT != 0) exp_cm.push_back({20'd0, g, 10'(n % MAX_PKT)});
        else                  exp_cm.push_back({20'd0, g, 10'd0});
        exp_pkts++;
    endfunction

    task automatic fill(input int s, input int n);
        slen[s] = n;
        for (int i = 0; i < n; i++) strm[s][i] = 8'($urandom);
    endtask

    task automatic send(input int s, input int stop);
        int i = 0, b = 0, n;
        n = (stop > 0) ? stop : slen[s];
        while (i < n && b < LIM) begin
            @(negedge ext_clk);
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                sv[s] = 1'b0; sl[s] = 1'b0;
            end else begin
                sv[s] = 1'b1; sd[s] = strm[s][i]; sl[s] = (stop == 0) && (i == n - 1);
            end
            #1;
            if (sv[s] && rdy_of(s)) i++;
            b++;
        end
        chk("send_budget", 32'(b < LIM), 32'd1);
        @(negedge ext_clk);
        sv[s] = 1'b0; sl[s] = 1'b0;
    endtask

    task automatic send_zlp(input int s);
        int b = 0;
        @(negedge ext_clk);
        sz[s] = 1'b1;
        #1;
        while (!rdy_of(s) && b < LIM) begin
            @(negedge ext_clk); #1; b++;
        end
        chk("zlp_budget", 32'(b < LIM), 32'd1);
        @(negedge ext_clk);
        sz[s] = 1'b0;
    endtask

    task automatic wait_done();
        int b = 0;
        while (!(act_cm.size() >= exp_cm.size() && grant == 2'b00 && !bif.buf_in_commit) && b < LIM) begin
            @(negedge ext_clk); #3; b++;
        end
        chk("done_budget", 32'(b < LIM), 32'd1);
    endtask

    task automatic check_queues(input string tag);
        int n;
        chk({tag, "_wr_count"}, 32'(act_wr.size()), 32'(exp_wr.size()));
        n = (act_wr.size() < exp_wr.size()) ? act_wr.size() : exp_wr.size();
        for (int i = 0; i < n; i++) chk({tag, "_wr"}, act_wr[i], exp_wr[i]);
        chk({tag, "_cm_count"}, 32'(act_cm.size()), 32'(exp_cm.size()));
        n = (act_cm.size() < exp_cm.size()) ? act_cm.size() : exp_cm.size();
        for (int i = 0; i < n; i++) chk({tag, "_commit"}, act_cm[i], exp_cm[i]);
        chk({tag, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkts & 16'hFFFF));
        act_wr.delete(); exp_wr.delete(); act_cm.delete(); exp_cm.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; sv = '0; sl = '0; sz = '0;
        repeat (3) @(negedge ext_clk);
        act_wr.delete(); exp_wr.delete(); act_cm.delete(); exp_cm.delete();
        exp_pkts = 0; wr_in_hold = 0; rdy_cnt[0] = 0; rdy_cnt[1] = 0;
        reset_n = 1'b1;
    endtask

    // Core-side responder and bus monitor, sampled mid-way between edges.
    initial begin : core
        logic pend_wr, pend_g, prev_commit, in_hold;
        logic [7:0] pend_d;
        logic [9:0] held_len;
        int dly, hold_cnt;
        pend_wr = 0; pend_g = 0; prev_commit = 0; in_hold = 0; pend_d = '0;
        held_len = '0; dly = 0; hold_cnt = 0;
        bif.buf_in_ready = 1'b1; bif.buf_in_commit_ack = 1'b0;
        forever begin
            @(negedge ext_clk); #2;
            if (!reset_n) begin
                pend_wr = 0; pend_g = 0; prev_commit = 0; hold_cnt = 0; in_hold = 0;
                bif.buf_in_commit_ack = 1'b0; bif.buf_in_ready = 1'b1;
                continue;
            end
            if (pend_wr) chk("byte_to_wren", {23'd0, bif.buf_in_wren, bif.buf_in_data}, {23'd0, 1'b1, pend_d});
            if (pend_g)  chk("req_to_grant", 32'(grant != 2'b00), 32'd1);
            if (bif.buf_in_wren) begin
                act_wr.push_back({13'd0, grant, bif.buf_in_addr, bif.buf_in_data});
                if (in_hold) wr_in_hold++;
            end
            if (bif.buf_in_commit && !prev_commit) begin
                chk("wren_before_commit", 32'(bif.buf_in_wren), 32'd0);
                held_len = bif.buf_in_commit_len;
            end else if (bif.buf_in_commit) begin
                chk("commit_len_stable", 32'(bif.buf_in_commit_len), 32'(held_len));
            end
            rdy_cnt[0] += int'(srdy0);
            rdy_cnt[1] += int'(srdy1);
            if (hold_cnt > 0) begin
                bif.buf_in_ready = 1'b0; hold_cnt--; in_hold = 1;
            end else begin
                in_hold = 0;
                bif.buf_in_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (bif.buf_in_commit_ack) begin
                bif.buf_in_commit_ack = 1'b0;
            end else if (bif.buf_in_commit) begin
                if (dly == 0) begin
                    bif.buf_in_commit_ack = 1'b1;
                    act_cm.push_back({20'd0, grant, bif.buf_in_commit_len});
                    dly = int'($urandom_range(0, ack_max));
                    if (hold_once > 0) begin hold_cnt = hold_once; hold_once = 0; end
                end else dly--;
            end
            prev_commit = bif.buf_in_commit;
            pend_wr = 0;
            if (sv[0] && srdy0) begin pend_wr = 1; pend_d = sd[0]; end
            if (sv[1] && srdy1) begin pend_wr = 1; pend_d = sd[1]; end
            pend_g = (grant == 2'b00) && bif.buf_in_ready && (|(sv | sz));
        end
    end

    initial begin : stim
        int len, s;
        reset_n = 1'b0; sv = '0; sl = '0; sz = '0; sd = '0;
        repeat (2) @(negedge ext_clk); #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_wren", 32'(bif.buf_in_wren), 32'd0);
        chk("rst_addr", 32'(bif.buf_in_addr), 32'd0);
        chk("rst_data", 32'(bif.buf_in_data), 32'd0);
        chk("rst_commit", 32'(bif.buf_in_commit), 32'd0);
        chk("rst_commit_len", 32'(bif.buf_in_commit_len), 32'd0);
        chk("rst_ready", {30'd0, srdy1, srdy0}, 32'd0);
        do_reset();
        repeat (2) @(negedge ext_clk); #3;
        chk("idle_no_req_busy", 32'(busy), 32'd0);

        // Three-byte packet from src0.
        slen[0] = 3; strm[0][0] = 8'hA1; strm[0][1] = 8'hA2; strm[0][2] = 8'hA3;
        model_stream(0, 3, 1);
        send(0, 0); wait_done();
        check_queues("s1");
        chk("s1_grant_released", 32'(grant), 32'd0);

        // Simultaneous requests alternate between sources.
        do_reset();
        fill(0, 4); fill(1, 3);
        model_stream(0, 4, 1); model_stream(1, 3, 1);
        fork send(0, 0); send(1, 0); join
        wait_done(); check_queues("s2a");
        model_stream(0, 4, 1); model_stream(1, 3, 1);
        fork send(0, 0); send(1, 0); join
        wait_done(); check_queues("s2b");
        fill(0, 2); model_stream(0, 2, 1);
        send(0, 0); wait_done(); check_queues("s2c");
        fill(0, 5); fill(1, 6);
        model_stream(1, 6, 1); model_stream(0, 5, 1);
        fork send(0, 0); send(1, 0); join
        wait_done(); check_queues("s2d");

        // Exactly MAX_PKT bytes with last: trailing ZLP under the same grant.
        do_reset();
        fill(1, 512); model_stream(1, 512, 1);
        send(1, 0); wait_done(); check_queues("s3");

        // 600 bytes split, buffer not ready for 20 cycles after the first commit.
        do_reset();
        fill(0, 600); model_stream(0, 600, 1); hold_once = 20;
        send(0, 0); wait_done(); check_queues("s4");
        chk("s4_no_wren_while_waiting", 32'(wr_in_hold), 32'd0);

        // Standalone zero-length packet.
        do_reset();
        model_stream(0, 0, 1);
        send_zlp(0); wait_done(); check_queues("s5");
        chk("s5_ready_pulses", 32'(rdy_cnt[0]), 32'd1);

        // Reset mid-FILL after five bytes.
        do_reset();
        fill(0, 3); model_stream(0, 3, 1);
        send(0, 0); wait_done(); check_queues("s6a");
        fill(0, 20); model_stream(0, 5, 0);
        send(0, 5);
        #3 reset_n = 1'b0;
        #1;
        chk("s6_rst_grant", 32'(grant), 32'd0);
        chk("s6_rst_busy", 32'(busy), 32'd0);
        chk("s6_rst_wren", 32'(bif.buf_in_wren), 32'd0);
        chk("s6_rst_commit", 32'(bif.buf_in_commit), 32'd0);
        chk("s6_rst_addr_data", {15'd0, bif.buf_in_addr, bif.buf_in_data}, 32'd0);
        chk("s6_rst_ready", {30'd0, srdy1, srdy0}, 32'd0);
        exp_pkts = 0;
        repeat (3) @(negedge ext_clk);
        check_queues("s6b");
        reset_n = 1'b1;
        fill(0, 3); model_stream(0, 3, 1);
        send(0, 0); wait_done(); check_queues("s6c");

        // Random streams with valid gaps, random ready and ack delay.
        do_reset();
        gap_pct = 25; rand_rdy = 1; ack_max = 3;
        for (int it = 0; it < 8; it++) begin
            s = int'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       len = 0;
                1:       len = 512;
                2:       len = 1024;
                default: len = int'($urandom_range(1, 700));
            endcase
            fill(s, len);
            model_stream(s, len, 1);
            if (len == 0) send_zlp(s);
            else          send(s, 0);
            wait_done();
            check_queues("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_buf_in_arbiter.md
Name: usb_buf_in_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the USB device core's single IN-endpoint packet buffer (buf_in_* port) between two byte-stream requesters.
- Per packet: grants one source, writes its bytes into the buffer at consecutive addresses, then drives the commit handshake with the packet length.
- Sits between application data sources and the USB core, in the ext_clk domain.

Parameters:
- MAX_PKT, 512, maximum packet payload in bytes. Range 1..512. A longer stream is split into MAX_PKT-sized packets.
- AUTO_ZLP, 1, when 1, a stream whose total length is a non-zero multiple of MAX_PKT is followed automatically by a zero-length commit.

Ports:
- ext_clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- src0_data  in  8  requester 0 byte.
- src0_valid  in  1  requester 0 byte valid.
- src0_last  in  1  requester 0 last byte of stream; qualified by src0_valid.
- src0_zlp  in  1  requester 0 level request for a zero-length packet; held until src0_ready.
- src0_ready  out  1  requester 0 byte/zlp accepted.
- src1_data, src1_valid, src1_last, src1_zlp, src1_ready  as for src0.
- buf_in_addr  out  9  buffer write address.
- buf_in_data  out  8  buffer write data.
- buf_in_wren  out  1  buffer write strobe.
- buf_in_ready  in  1  core buffer free for a new packet.
- buf_in_commit  out  1  commit request, level.
- buf_in_commit_len  out  10  committed byte count.
- buf_in_commit_ack  in  1  core accepted commit.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  state != IDLE.
- pkt_count  out  16  committed packets, wraps at 65535->0.

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer favours src0, byte counter 0.
- IDLE:
  - Request_i = src_i_valid | src_i_zlp.
  - When buf_in_ready=1 and any request is present, grant next cycle and go to FILL.
  - Both requesting: grant the source not granted last.
  - Single requester: grant it regardless of pointer.
  - buf_in_ready=0: stay in IDLE.
- FILL:
  - src_ready of the owner = 1 combinationally; other source's ready = 0.
  - On valid&ready, register a write: next cycle buf_in_wren=1, buf_in_addr=count[8:0], buf_in_data=byte. count++.
  - One byte per cycle maximum.
  - Accepted byte with last=1, or count reaching MAX_PKT: go to COMMIT.
  - zlp=1 while count=0 and valid=0: accept it (ready=1 for one cycle) and go to COMMIT with len 0. zlp is ignored when valid=1.
  - buf_in_ready is not re-checked during FILL.
- COMMIT:
  - buf_in_commit=1, buf_in_commit_len=count. Both held stable until buf_in_commit_ack is sampled high.
  - On ack: commit drops next cycle, pkt_count++, count=0.
  - Continuation rules after ack:
    - Split (MAX_PKT reached without last): go to WAIT_RDY and keep grant.
    - Last byte exactly filled MAX_PKT and AUTO_ZLP=1: go to WAIT_RDY, keep grant, zlp_pending=1.
    - Otherwise: release grant, update rr pointer, go to IDLE.
  - The last wren precedes commit by ≥1 cycle.
- WAIT_RDY:
  - Owner's ready = 0. Wait for buf_in_ready=1.
  - Then go to FILL, or to COMMIT with len 0 if zlp_pending; clear zlp_pending.
- A source may drop valid mid-stream. The grant is held indefinitely until last, or until zlp at count=0. No timeout.
- Ack arriving when commit=0 is ignored.
- Reset mid-operation aborts immediately. No commit is issued for partial data.
- Latency: grant 1 cycle after request; byte to wren 1 cycle; last byte to commit 1 cycle.

Decomposition:
- Package usb_buf_arb_pkg: state enum (IDLE, FILL, COMMIT, WAIT_RDY), MAX_PKT default, length width constant (10).
- Sub-module usb_rr_arb2: 2-way round-robin arbiter, combinational grant plus registered pointer updated on release.

Test Plan:
- Src0 sends 3 bytes A1,A2,A3 (last on A3), buf_in_ready=1 -> wren at addr 0,1,2 with the same data; commit_len=3; after ack, grant=00, pkt_count=1.
- Src0 and src1 both valid from reset -> src0 granted first, then src1; a second simultaneous request after that grants src0 (alternation).
- Src1 streams 512 bytes, MAX_PKT=512, AUTO_ZLP=1 -> commit len 512, then a second commit len 0 without a grant change; pkt_count=2.
- Src0 streams 600 bytes with MAX_PKT=512, buf_in_ready low for 20 cycles after the first ack -> commits of 512 and 88; no wren while waiting.
- Src0 zlp=1 alone -> src0_ready pulses once, commit_len=0, no wren.
- reset_n asserted mid-FILL after 5 bytes -> all outputs 0 immediately; no commit; next request starts at addr 0.
